// File: rtl/imem_pkg.sv
// ----------------------------------------------------------------------------
// imem_pkg
// Shared definitions for the synchronous instruction memory and its byte-serial
// program loader: instruction width, the canonical RV32I NOP, the loader state
// encoding and a small helper for PC alignment.
// ----------------------------------------------------------------------------
package imem_pkg;

    // RV32I instructions are always one 32-bit word.
    localparam int INSTR_W = 32;

    // addi x0, x0, 0 -- what the fetch stage sees whenever there is no real fetch.
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

    // Loader FSM encoding, kept as plain constants for older tool flows.
    localparam int STATE_W = 1;
    localparam logic [STATE_W-1:0] ST_RUN  = 1'b0;
    localparam logic [STATE_W-1:0] ST_LOAD = 1'b1;

    // A fetch address is legal only when it is word aligned.
    function automatic logic isMisaligned(input logic [1:0] pcLow);
        return (pcLow != 2'b00);
    endfunction

endpackage

// File: rtl/imem_byte_loader.sv
// ----------------------------------------------------------------------------
// imem_byte_loader
// Run-time program loader for imem_sync. Owns the RUN/LOAD state machine,
// collects a little-endian byte stream into 32-bit words and issues one memory
// write per completed word. A trailing partial word is zero-padded and written
// when the stream ends. Writing stops once every word of the memory has been
// filled; later bytes are discarded rather than wrapping.
//
// Ports
//   i_Clk          clock, rising edge
//   i_Rstn         synchronous active-low reset
//   i_LdStart      pulse: enter load mode (only honoured in RUN)
//   i_LdByteValid  i_LdByte carries a program byte this cycle
//   i_LdByte       program byte
//   i_LdDone       pulse: end of the byte stream
//   o_We           memory write enable
//   o_WAddr        memory word address to write
//   o_WData        memory word to write
//   o_Busy         load mode active
//   o_Count        words written in the current/last load
// ----------------------------------------------------------------------------
module imem_byte_loader
    import imem_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic               i_Clk,
    input  logic               i_Rstn,
    input  logic               i_LdStart,
    input  logic               i_LdByteValid,
    input  logic [7:0]         i_LdByte,
    input  logic               i_LdDone,
    output logic               o_We,
    output logic [ADDR_W-1:0]  o_WAddr,
    output logic [INSTR_W-1:0] o_WData,
    output logic               o_Busy,
    output logic [ADDR_W:0]    o_Count
);

    logic [STATE_W-1:0] state_q, state_d;
    logic [1:0]         lane_q, lane_d;
    logic [INSTR_W-1:0] asm_q, asm_d;
    logic [ADDR_W:0]    count_q, count_d;
    logic [INSTR_W-1:0] merged;
    logic               full;

    // The word counter doubles as the write pointer; its top bit set means
    // every location has been written exactly once in this load.
    assign full = count_q[ADDR_W];

    // Assembly register with the incoming byte dropped into the current lane.
    always_comb begin
        merged = asm_q;
        case (lane_q)
            2'd0:    merged[7:0]   = i_LdByte;
            2'd1:    merged[15:8]  = i_LdByte;
            2'd2:    merged[23:16] = i_LdByte;
            default: merged[31:24] = i_LdByte;
        endcase
    end

    // Next-state logic. Within a LOAD cycle the byte is consumed first, and the
    // end-of-stream handling then looks at the post-byte lane/count, so a byte
    // and done arriving together behave like byte-then-done. A byte completing
    // a word and done never both write: completing a word returns lane to 0.
    always_comb begin
        state_d = state_q;
        lane_d  = lane_q;
        asm_d   = asm_q;
        count_d = count_q;
        o_We    = 1'b0;
        o_WData = '0;

        case (state_q)
            ST_RUN: begin
                if (i_LdStart) begin
                    state_d = ST_LOAD;
                    lane_d  = 2'd0;
                    asm_d   = '0;
                    count_d = '0;
                end
            end

            ST_LOAD: begin
                if (i_LdByteValid && !full) begin
                    if (lane_q == 2'd3) begin
                        o_We    = 1'b1;
                        o_WData = merged;
                        count_d = count_q + 1'b1;
                        lane_d  = 2'd0;
                        asm_d   = '0;
                    end else begin
                        asm_d  = merged;
                        lane_d = lane_q + 2'd1;
                    end
                end

                if (i_LdDone) begin
                    // Unused upper lanes of asm_d are already zero, which gives
                    // the zero padding for free.
                    if ((lane_d != 2'd0) && !count_d[ADDR_W]) begin
                        o_We    = 1'b1;
                        o_WData = asm_d;
                        count_d = count_d + 1'b1;
                    end
                    lane_d  = 2'd0;
                    asm_d   = '0;
                    state_d = ST_RUN;
                end
            end

            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // State registers. Reset drops any partially assembled word; words already
    // written stay in the memory array, which has no reset.
    always_ff @(posedge i_Clk) begin
        if (!i_Rstn) begin
            state_q <= ST_RUN;
            lane_q  <= 2'd0;
            asm_q   <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
            asm_q   <= asm_d;
            count_q <= count_d;
        end
    end

    // A partial-word write at done always targets the current pointer, since a
    // non-completing byte leaves the count untouched.
    assign o_WAddr = count_q[ADDR_W-1:0];
    assign o_Busy  = (state_q == ST_LOAD);
    assign o_Count = count_q;

endmodule

// File: rtl/imem_sync.sv
// ----------------------------------------------------------------------------
// imem_sync
// Synchronous-read instruction memory for the RV32I fetch stage. Fetch has one
// cycle of latency through a registered read port, with stall (hold outputs),
// flush (emit a NOP) and misaligned-PC fault reporting. A byte-serial loader
// refills the array at run time; fetching is suppressed while it runs, so the
// single read port and single write port never collide.
//
// Ports
//   i_Clk          clock, rising edge
//   i_Rstn         synchronous active-low reset
//   i_Pc           byte address from the PC
//   i_Req          fetch request
//   i_Stall        hold the current fetch outputs
//   i_Flush        kill the fetch in flight, emit NOP
//   o_Instr        fetched instruction
//   o_Valid        o_Instr is a real fetch result
//   o_Fault        fetch address was misaligned
//   i_LdStart      pulse: enter load mode
//   i_LdByteValid  i_LdByte valid this cycle
//   i_LdByte       program byte, little-endian stream
//   i_LdDone       pulse: end of the load stream
//   o_LdBusy       load mode active
//   o_LdCount      words written in the current/last load
// ----------------------------------------------------------------------------
module imem_sync
    import imem_pkg::*;
#(
    parameter int                 ADDR_W    = 10,
    parameter logic [INSTR_W-1:0] NOP_INSTR = imem_pkg::NOP_INSTR,
    parameter string              INIT_FILE = ""
) (
    input  logic               i_Clk,
    input  logic               i_Rstn,
    input  logic [ADDR_W+1:0]  i_Pc,
    input  logic               i_Req,
    input  logic               i_Stall,
    input  logic               i_Flush,
    output logic [INSTR_W-1:0] o_Instr,
    output logic               o_Valid,
    output logic               o_Fault,
    input  logic               i_LdStart,
    input  logic               i_LdByteValid,
    input  logic [7:0]         i_LdByte,
    input  logic               i_LdDone,
    output logic               o_LdBusy,
    output logic [ADDR_W:0]    o_LdCount
);

    localparam int DEPTH = 2 ** ADDR_W;

    // INIT_FILE names an image for flows that preload the array outside this
    // RTL; the design itself only fills memory through the byte loader.
    logic [INSTR_W-1:0] memArray [DEPTH];

    logic               ldWe;
    logic [ADDR_W-1:0]  ldWAddr;
    logic [INSTR_W-1:0] ldWData;
    logic               ldBusy;
    logic [ADDR_W:0]    ldCount;

    logic [INSTR_W-1:0] instr_q;
    logic               valid_q;
    logic               fault_q;
    logic [ADDR_W-1:0]  wordIdx;

    assign wordIdx = i_Pc[ADDR_W+1:2];

    imem_byte_loader #(
        .ADDR_W (ADDR_W)
    ) u_loader (
        .i_Clk         (i_Clk),
        .i_Rstn        (i_Rstn),
        .i_LdStart     (i_LdStart),
        .i_LdByteValid (i_LdByteValid),
        .i_LdByte      (i_LdByte),
        .i_LdDone      (i_LdDone),
        .o_We          (ldWe),
        .o_WAddr       (ldWAddr),
        .o_WData       (ldWData),
        .o_Busy        (ldBusy),
        .o_Count       (ldCount)
    );

    // Write port, fed only by the loader. No reset: contents survive reset.
    always_ff @(posedge i_Clk) begin
        if (ldWe) begin
            memArray[ldWAddr] <= ldWData;
        end
    end

    // Registered read port plus fetch-output register. Priority is reset,
    // then load activity (LOAD, or the start edge whose fetch is dropped),
    // then flush, stall, and finally a normal request.
    always_ff @(posedge i_Clk) begin
        if (!i_Rstn) begin
            instr_q <= NOP_INSTR;
            valid_q <= 1'b0;
            fault_q <= 1'b0;
        end else if (ldBusy || i_LdStart) begin
            instr_q <= NOP_INSTR;
            valid_q <= 1'b0;
            fault_q <= 1'b0;
        end else if (i_Flush) begin
            instr_q <= NOP_INSTR;
            valid_q <= 1'b0;
            fault_q <= 1'b0;
        end else if (i_Stall) begin
            instr_q <= instr_q;
            valid_q <= valid_q;
            fault_q <= fault_q;
        end else if (i_Req) begin
            // A misaligned fetch still reports valid so the pipeline can trap.
            if (isMisaligned(i_Pc[1:0])) begin
                instr_q <= NOP_INSTR;
                fault_q <= 1'b1;
            end else begin
                instr_q <= memArray[wordIdx];
                fault_q <= 1'b0;
            end
            valid_q <= 1'b1;
        end else begin
            instr_q <= NOP_INSTR;
            valid_q <= 1'b0;
            fault_q <= 1'b0;
        end
    end

    assign o_Instr   = instr_q;
    assign o_Valid   = valid_q;
    assign o_Fault   = fault_q;
    assign o_LdBusy  = ldBusy;
    assign o_LdCount = ldCount;

endmodule

// File: tb/tb_imem_sync.sv
// ----------------------------------------------------------------------------
// tb_imem_sync
// Directed bench for imem_sync: a full-size instance exercises fetch, stall,
// flush, faults and loading; a 4-word instance exercises the full condition.
// ----------------------------------------------------------------------------
module tb_imem_sync;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rstn;

    // Full-size instance signals
    logic [11:0] pc;
    logic        req, stall, flush;
    logic [31:0] instr;
    logic        valid, fault;
    logic        ldStart, ldByteValid, ldDone;
    logic [7:0]  ldByte;
    logic        ldBusy;
    logic [10:0] ldCount;

    // Small instance signals
    logic [3:0]  sPc;
    logic        sReq;
    logic [31:0] sInstr;
    logic        sValid, sFault;
    logic        sLdStart, sLdByteValid, sLdDone;
    logic [7:0]  sLdByte;
    logic        sLdBusy;
    logic [2:0]  sLdCount;

    int errCount   = 0;
    int checkCount = 0;

    imem_sync #(.ADDR_W(10)) dut (
        .i_Clk(clk), .i_Rstn(rstn), .i_Pc(pc), .i_Req(req), .i_Stall(stall),
        .i_Flush(flush), .o_Instr(instr), .o_Valid(valid), .o_Fault(fault),
        .i_LdStart(ldStart), .i_LdByteValid(ldByteValid), .i_LdByte(ldByte),
        .i_LdDone(ldDone), .o_LdBusy(ldBusy), .o_LdCount(ldCount)
    );

    imem_sync #(.ADDR_W(2)) dutSmall (
        .i_Clk(clk), .i_Rstn(rstn), .i_Pc(sPc), .i_Req(sReq), .i_Stall(1'b0),
        .i_Flush(1'b0), .o_Instr(sInstr), .o_Valid(sValid), .o_Fault(sFault),
        .i_LdStart(sLdStart), .i_LdByteValid(sLdByteValid), .i_LdByte(sLdByte),
        .i_LdDone(sLdDone), .o_LdBusy(sLdBusy), .o_LdCount(sLdCount)
    );

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        req;
        logic        stall;
        logic        flush;
        logic [11:0] pc;
        logic [31:0] expInstr;
        logic        expValid;
        logic        expFault;
    } fetchVec_t;

    fetchVec_t vecs[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // One fetch-side cycle on the full-size instance.
    task automatic applyStimulus(input logic r, input logic s, input logic f, input logic [11:0] p);
        req   = r;
        stall = s;
        flush = f;
        pc    = p;
        tick();
        req   = 1'b0;
        stall = 1'b0;
        flush = 1'b0;
    endtask

    task automatic loadByte(input logic [7:0] b, input logic done);
        ldByteValid = 1'b1;
        ldByte      = b;
        ldDone      = done;
        tick();
        ldByteValid = 1'b0;
        ldDone      = 1'b0;
    endtask

    task automatic sLoadByte(input logic [7:0] b);
        sLdByteValid = 1'b1;
        sLdByte      = b;
        tick();
        sLdByteValid = 1'b0;
    endtask

    task automatic fetchCheck(input string name, input logic [11:0] p, input logic [31:0] exp);
        applyStimulus(1'b1, 1'b0, 1'b0, p);
        checkOutput({name, "_instr"}, instr, exp);
        checkOutput({name, "_valid"}, {31'd0, valid}, 32'd1);
    endtask

    task automatic sFetchCheck(input string name, input logic [3:0] p, input logic [31:0] exp);
        sReq = 1'b1;
        sPc  = p;
        tick();
        sReq = 1'b0;
        checkOutput(name, sInstr, exp);
    endtask

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        logic [31:0] preload [4];

        rstn = 1'b0;
        pc = '0; req = 0; stall = 0; flush = 0;
        ldStart = 0; ldByteValid = 0; ldDone = 0; ldByte = '0;
        sPc = '0; sReq = 0; sLdStart = 0; sLdByteValid = 0; sLdDone = 0; sLdByte = '0;

        preload[0] = 32'h0000_0013;
        preload[1] = 32'h0010_0093;
        preload[2] = 32'h0010_0313;
        preload[3] = 32'h0040_0613;

        // Reset state
        tick();
        tick();
        checkOutput("rst_instr", instr, NOP);
        checkOutput("rst_valid", {31'd0, valid}, 32'd0);
        checkOutput("rst_fault", {31'd0, fault}, 32'd0);
        checkOutput("rst_busy", {31'd0, ldBusy}, 32'd0);
        checkOutput("rst_count", {21'd0, ldCount}, 32'd0);
        rstn = 1'b1;
        tick();

        // Preload the first four words through the loader.
        ldStart = 1'b1;
        tick();
        ldStart = 1'b0;
        checkOutput("pre_busy", {31'd0, ldBusy}, 32'd1);
        for (int w = 0; w < 4; w++) begin
            for (int b = 0; b < 4; b++) begin
                loadByte(preload[w][8*b +: 8], (w == 3 && b == 3));
            end
        end
        checkOutput("pre_count", {21'd0, ldCount}, 32'd4);
        checkOutput("pre_busy_low", {31'd0, ldBusy}, 32'd0);

        // Fetch / stall / flush / fault vectors. Expected values describe the
        // outputs right after the edge that samples the row's inputs.
        vecs.push_back('{"f_pc0",        1, 0, 0, 12'h000, 32'h0000_0013, 1, 0});
        vecs.push_back('{"f_pc4",        1, 0, 0, 12'h004, 32'h0010_0093, 1, 0});
        vecs.push_back('{"f_pc8",        1, 0, 0, 12'h008, 32'h0010_0313, 1, 0});
        vecs.push_back('{"f_pc12",       1, 0, 0, 12'h00C, 32'h0040_0613, 1, 0});
        vecs.push_back('{"f_mis6",       1, 0, 0, 12'h006, NOP,           1, 1});
        vecs.push_back('{"f_noreq",      0, 0, 0, 12'h000, NOP,           0, 0});
        vecs.push_back('{"f_pc4b",       1, 0, 0, 12'h004, 32'h0010_0093, 1, 0});
        vecs.push_back('{"stall1",       1, 1, 0, 12'h008, 32'h0010_0093, 1, 0});
        vecs.push_back('{"stall2",       0, 1, 0, 12'h000, 32'h0010_0093, 1, 0});
        vecs.push_back('{"stall3",       1, 1, 0, 12'h006, 32'h0010_0093, 1, 0});
        vecs.push_back('{"flush_stall",  1, 1, 1, 12'h008, NOP,           0, 0});
        vecs.push_back('{"f_mis1",       1, 0, 0, 12'h001, NOP,           1, 1});
        vecs.push_back('{"stall_fault",  1, 1, 0, 12'h00C, NOP,           1, 1});
        vecs.push_back('{"flush_req",    1, 0, 1, 12'h004, NOP,           0, 0});
        vecs.push_back('{"stall_idle",   1, 1, 0, 12'h004, NOP,           0, 0});
        vecs.push_back('{"f_pc12b",      1, 0, 0, 12'h00C, 32'h0040_0613, 1, 0});

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].req, vecs[i].stall, vecs[i].flush, vecs[i].pc);
            checkOutput({vecs[i].name, "_instr"}, instr, vecs[i].expInstr);
            checkOutput({vecs[i].name, "_valid"}, {31'd0, valid}, {31'd0, vecs[i].expValid});
            checkOutput({vecs[i].name, "_fault"}, {31'd0, fault}, {31'd0, vecs[i].expFault});
        end

        // Load with partial final word; a request held through the load and
        // on the start edge must never produce a valid fetch.
        req = 1'b1;
        pc  = 12'h000;
        ldStart = 1'b1;
        tick();
        ldStart = 1'b0;
        checkOutput("ld_start_valid", {31'd0, valid}, 32'd0);
        checkOutput("ld_start_busy", {31'd0, ldBusy}, 32'd1);
        checkOutput("ld_start_count", {21'd0, ldCount}, 32'd0);
        loadByte(8'h13, 1'b0);
        loadByte(8'h05, 1'b0);
        loadByte(8'h00, 1'b0);
        loadByte(8'h01, 1'b0);
        checkOutput("ld_count1", {21'd0, ldCount}, 32'd1);
        checkOutput("ld_mid_valid", {31'd0, valid}, 32'd0);
        loadByte(8'h93, 1'b0);
        loadByte(8'h03, 1'b1);
        req = 1'b0;
        checkOutput("ld_count2", {21'd0, ldCount}, 32'd2);
        checkOutput("ld_busy_low", {31'd0, ldBusy}, 32'd0);
        checkOutput("ld_done_valid", {31'd0, valid}, 32'd0);
        fetchCheck("ld_w0", 12'h000, 32'h0100_0513);
        fetchCheck("ld_w1", 12'h004, 32'h0000_0393);
        fetchCheck("ld_w2_kept", 12'h008, 32'h0010_0313);

        // Reset in the middle of a load.
        ldStart = 1'b1;
        tick();
        ldStart = 1'b0;
        loadByte(8'hDD, 1'b0);
        loadByte(8'hCC, 1'b0);
        loadByte(8'hBB, 1'b0);
        loadByte(8'hAA, 1'b0);
        loadByte(8'h11, 1'b0);
        loadByte(8'h22, 1'b0);
        rstn = 1'b0;
        tick();
        checkOutput("mr_busy", {31'd0, ldBusy}, 32'd0);
        checkOutput("mr_count", {21'd0, ldCount}, 32'd0);
        rstn = 1'b1;
        fetchCheck("mr_w0", 12'h000, 32'hAABB_CCDD);
        fetchCheck("mr_w1_kept", 12'h004, 32'h0000_0393);

        // Small instance: 20 bytes into a 4-word memory.
        sLdStart = 1'b1;
        tick();
        sLdStart = 1'b0;
        for (int k = 0; k < 20; k++) begin
            sLoadByte(8'h10 + 8'(k));
            if (k == 15) checkOutput("sm_count_full", {29'd0, sLdCount}, 32'd4);
        end
        checkOutput("sm_count_sat", {29'd0, sLdCount}, 32'd4);
        checkOutput("sm_busy", {31'd0, sLdBusy}, 32'd1);
        sLdDone = 1'b1;
        tick();
        sLdDone = 1'b0;
        checkOutput("sm_done_count", {29'd0, sLdCount}, 32'd4);
        checkOutput("sm_done_busy", {31'd0, sLdBusy}, 32'd0);
        sFetchCheck("sm_w0", 4'h0, 32'h1312_1110);
        sFetchCheck("sm_w1", 4'h4, 32'h1716_1514);
        sFetchCheck("sm_w2", 4'h8, 32'h1B1A_1918);
        sFetchCheck("sm_w3", 4'hC, 32'h1F1E_1D1C);

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
